draw_point_fb_writer: RTL and testbench

Responder (slave end) of the draw-point protocol. Accepts single-pixel updates (position + RGB12 colour) from a drawing master, clips them against the screen, converts X/Y to a linear frame-buffer address, buffers them in a small FIFO, and drains them to the frame-buffer RAM write port through a request/grant handshake shared with the VGA readout arbiter.

---
 rtl/draw_point_fb_writer_pkg.sv | 23 ++
 rtl/draw_point_fb_writer_sync_fifo.sv | 56 +++++
 rtl/draw_point_fb_writer.sv | 105 ++++++++++
 tb/tb_draw_point_fb_writer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_point_fb_writer_pkg.sv
// Shared constants and entry type for the draw-point
// frame-buffer writer.
package pkg_DrawPoint;

  localparam int H_RES_DEF      = 320;
  localparam int V_RES_DEF      = 240;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int FB_ADDR_W      = 17;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [11:0]          rgb;
  } tDrawPointEntry;

  // Points per frame buffer; the address space must cover it.
  function automatic int fb_size(
    input int h,
    input int v
  );
    return h * v;
  endfunction

endpackage

// File: rtl/draw_point_fb_writer_sync_fifo.sv
// Plain synchronous FIFO with push/pop/count.
// Any drop policy belongs to the instantiating block.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/draw_point_fb_writer.sv
// Draw-point responder: clip, address, buffer and drain
// single-pixel updates into the frame-buffer write port.
module draw_point_fb_writer
  import pkg_DrawPoint::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_W     = FB_ADDR_W
) (
  input  logic              ul1Clock,
  input  logic              ul1Reset_n,
  input  logic              ul1Update,
  input  logic [8:0]        ul9PosX,
  input  logic [8:0]        ul9PosY,
  input  logic [11:0]       ul12Rgb12Data,
  output logic              ul1FbReq,
  output logic [ADDR_W-1:0] ulFbAddr,
  output logic [11:0]       ul12FbData,
  input  logic              ul1FbGnt,
  input  logic              ul1ClearFlags,
  output logic              ul1Overflow,
  output logic              ul1ClipErr,
  output logic              ul1Busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_W + 12;

  logic              in_range;
  logic [ADDR_W-1:0] pt_addr;
  logic              push_try;
  logic              push;
  logic              pop;
  logic              drop;
  logic              clip_evt;
  logic              write_done;
  logic              load_en;
  logic [EW-1:0]     head;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;

  assign in_range = (int'(ul9PosX) < H_RES)
                 && (int'(ul9PosY) < V_RES);

  // Constant multiply; synthesis folds it to shifts and adds.
  assign pt_addr = ADDR_W'(ul9PosY) * ADDR_W'(H_RES)
                 + ADDR_W'(ul9PosX);

  assign write_done = ul1FbReq & ul1FbGnt;
  assign load_en    = ~ul1FbReq | write_done;
  assign pop        = load_en & ~empty;

  assign push_try = ul1Update & in_range;
  assign clip_evt = ul1Update & ~in_range;
  // A full FIFO still takes a point if it drains this cycle.
  assign push     = push_try & (~full | pop);
  assign drop     = push_try & ~push;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ul1Clock),
    .rst_n   (ul1Reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data ({pt_addr, ul12Rgb12Data}),
    .rd_data (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  always_ff @(posedge ul1Clock) begin
    if (!ul1Reset_n) begin
      ul1FbReq   <= 1'b0;
      ulFbAddr   <= '0;
      ul12FbData <= '0;
    end else if (load_en) begin
      ul1FbReq <= ~empty;
      if (!empty) begin
        ulFbAddr   <= head[EW-1:12];
        ul12FbData <= head[11:0];
      end
    end
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge ul1Clock) begin
    if (!ul1Reset_n) begin
      ul1Overflow <= 1'b0;
      ul1ClipErr  <= 1'b0;
    end else begin
      ul1Overflow <= drop
                  | (ul1Overflow & ~ul1ClearFlags);
      ul1ClipErr  <= clip_evt
                  | (ul1ClipErr & ~ul1ClearFlags);
    end
  end

  assign ul1Busy = (count != '0) | ul1FbReq;

endmodule

// File: tb/tb_draw_point_fb_writer.sv
// Directed and random bench for draw_point_fb_writer
// against a pending-point queue model.
module tb_draw_point_fb_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd = 1'b0;
  logic [8:0]  px = '0;
  logic [8:0]  py = '0;
  logic [11:0] rgb = '0;
  logic        gnt = 1'b0;
  logic        clr = 1'b0;
  logic        fb_req;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;
  logic        ovf;
  logic        clip;
  logic        busy;

  draw_point_fb_writer #(
    .H_RES      (320),
    .V_RES      (240),
    .FIFO_DEPTH (4),
    .ADDR_W     (17)
  ) dut (
    .ul1Clock      (clk),
    .ul1Reset_n    (rst_n),
    .ul1Update     (upd),
    .ul9PosX       (px),
    .ul9PosY       (py),
    .ul12Rgb12Data (rgb),
    .ul1FbReq      (fb_req),
    .ulFbAddr      (fb_addr),
    .ul12FbData    (fb_data),
    .ul1FbGnt      (gnt),
    .ul1ClearFlags (clr),
    .ul1Overflow   (ovf),
    .ul1ClipErr    (clip),
    .ul1Busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int rgb;
    int stamp;
  } ent_t;

  ent_t q[$];
  int   log_a[$];
  int   log_d[$];
  int   k = 0;
  bit   m_req = 0;
  bit   m_ovf = 0;
  bit   m_clip = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   base;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Model: every accepted-but-unwritten point, oldest first.
  // The head is presented one edge after acceptance.
  task automatic step();
    bit done;
    bit set_o;
    bit set_c;
    int sz;
    int xi;
    int yi;
    if (rst_n && fb_req && gnt) begin
      log_a.push_back(int'(fb_addr));
      log_d.push_back(int'(fb_data));
    end
    @(posedge clk);
    k++;
    if (!rst_n) begin
      q.delete();
      m_ovf  = 0;
      m_clip = 0;
    end else begin
      done  = m_req && gnt;
      sz    = q.size();
      set_o = 0;
      set_c = 0;
      if (done) void'(q.pop_front());
      if (upd) begin
        xi = int'(px);
        yi = int'(py);
        if (xi >= 320 || yi >= 240) set_c = 1;
        else if (sz < 5 || done)
          q.push_back('{yi * 320 + xi, int'(rgb), k});
        else set_o = 1;
      end
      m_ovf  = set_o | (m_ovf & !clr);
      m_clip = set_c | (m_clip & !clr);
    end
    m_req = q.size() > 0 && q[0].stamp < k;
    #1;
    check("req", fb_req, m_req);
    check("busy", busy, q.size() != 0);
    check("ovf", ovf, m_ovf);
    check("clip", clip, m_clip);
    if (m_req) begin
      check("addr", fb_addr, q[0].addr);
      check("data", fb_data, q[0].rgb);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic put(
    input int x,
    input int y,
    input int c
  );
    upd = 1'b1;
    px  = 9'(x);
    py  = 9'(y);
    rgb = 12'(c);
    step();
    upd = 1'b0;
  endtask

  initial begin
    idle(2);
    check("rst_req", fb_req, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(1);

    // single point
    gnt  = 1'b1;
    base = log_a.size();
    put(5, 2, 12'hABC);
    check("t1_lat", fb_req, 0);
    step();
    check("t1_req", fb_req, 1);
    check("t1_addr", fb_addr, 645);
    check("t1_data", fb_data, 12'hABC);
    step();
    check("t1_drop", fb_req, 0);
    idle(2);
    check("t1_n", log_a.size(), base + 1);
    check("t1_log", log_a[base], 645);

    // corners and clipping
    base = log_a.size();
    put(0, 0, 1);
    put(319, 239, 2);
    put(320, 0, 3);
    idle(3);
    check("t2_n", log_a.size(), base + 2);
    check("t2_a0", log_a[base], 0);
    check("t2_a1", log_a[base + 1], 76799);
    check("t2_clip", clip, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t2_clr", clip, 0);

    // overflow with grant held low
    gnt  = 1'b0;
    base = log_a.size();
    for (int i = 0; i < 6; i++) put(i, 1, 12'h100 + i);
    check("t3_ovf", ovf, 1);
    idle(3);
    gnt = 1'b1;
    idle(7);
    check("t3_n", log_a.size(), base + 5);
    for (int i = 0; i < 5; i++) begin
      check("t3_a", log_a[base + i], 320 + i);
      check("t3_d", log_d[base + i], 12'h100 + i);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;

    // full FIFO, grant and push together
    gnt  = 1'b0;
    base = log_a.size();
    for (int i = 0; i < 5; i++) put(i, 3, i);
    gnt = 1'b1;
    put(9, 9, 12'h999);
    check("t4_ovf", ovf, 0);
    idle(8);
    check("t4_n", log_a.size(), base + 6);
    check("t4_last", log_a[base + 5], 2889);

    // reset with points pending
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) put(i, 7, i);
    rst_n = 1'b0;
    put(1, 1, 12'h111);
    check("t5_req", fb_req, 0);
    check("t5_busy", busy, 0);
    rst_n = 1'b1;
    gnt   = 1'b1;
    base  = log_a.size();
    idle(5);
    check("t5_n", log_a.size(), base);

    // random traffic and grant duty cycle
    for (int n = 0; n < 1000; ) begin
      gnt = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        put($urandom_range(0, 319),
            $urandom_range(0, 239),
            $urandom_range(0, 4095));
        n++;
      end else begin
        step();
      end
    end
    gnt = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    check("drain", q.size(), 0);
    check("end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
